convo_tile_sequencer: RTL and testbench
=======================================

# convo_tile_sequencer

Controller that sequences the binary XNOR/popcount convolution math unit (3x3 binary kernel over a 4x4 binary tile, 2x2 binary result). It holds the kernel weights, accepts input tiles over a valid/ready stream, and drives the math unit's `w`/`i`/`dataSel` inputs. It captures each 4-bit result and packs consecutive results into 16-bit output words on a second valid/ready stream. It sits between the tile fetch logic and the feature-map write-back path.

## Interface
- `SETTLE_CYCLES`, default 1: cycles `math_sel` is held high before the result is captured; legal range 1..15.
- `PACK`, default 4: result nibbles per output word; legal range 1..4.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `w_load` in 1: weight load strobe.
- `w_data` in 9: kernel bits; bit 0 is the top-left tap, bit 8 the bottom-right.
- `tile_valid` in 1, `tile_ready` out 1, `tile_data` in 16, `tile_last` in 1: input tile stream; `tile_last` forces a flush.
- `math_w` out 16: `{7'b0, weight}` to the math unit.
- `math_i` out 16: latched tile to the math unit.
- `math_sel` out 1: dataSel to the math unit.
- `math_result` in 16: math unit output; only bits [3:0] are used.
- `out_valid` out 1, `out_ready` in 1, `out_data` out 16, `out_count` out 3, `out_last` out 1: packed output stream.
- `busy` out 1: high in any state other than IDLE.

## Operation
- **Weight register.** `weight`[8:0] and `w_valid` flag.
  - `w_load` is honoured only in IDLE: `weight <= w_data`, `w_valid <= 1`.
  - `w_load` in any other state is ignored, not queued.
- **States:**
  - IDLE: `tile_ready = w_valid`. On handshake, latch `tile_data` into `math_i` and `tile_last` into `last_r`, then go to DRIVE.
  - DRIVE: `math_sel = 1`; the settle counter counts SETTLE_CYCLES cycles, then the FSM goes to CAPTURE.
  - CAPTURE: `math_sel = 1`. Write `math_result[3:0]` into `pack[4*idx+3:4*idx]` and increment `idx`. If `idx+1 == PACK` or `last_r`, go to EMIT; otherwise return to IDLE.
  - EMIT: `out_valid = 1`. On `out_ready`, clear `pack`, `idx` and `last_r`, then return to IDLE.
- **Output word.**
  - `out_data = pack`; unfilled nibbles are 0.
  - `out_count` = number of filled nibbles (1..PACK).
  - `out_last = last_r`.
- **Selection and holding.**
  - `math_sel = 0` in IDLE and EMIT.
  - `math_i` holds its last tile between operations.
- **Simultaneous events.**
  - `w_load` and a tile handshake in the same IDLE cycle: the weight updates, and the tile is computed with the new weight, because DRIVE starts the next cycle.
  - If `w_valid` was 0 in that cycle, `tile_ready` is 0, so no tile is accepted.
- **Reset.**
  - All outputs go to 0; `weight`, `w_valid`, `pack`, `idx` and `last_r` are cleared; the FSM goes to IDLE.
  - Reset mid-operation discards the in-flight tile and any partial word without emitting them.
  - After reset, `tile_ready` stays 0 until a new `w_load`.

## Timing
- Tile accepted at cycle T:
  - DRIVE occupies T+1 .. T+SETTLE_CYCLES.
  - CAPTURE occurs at T+SETTLE_CYCLES+1.
  - When the word flushes, `out_valid` rises at T+SETTLE_CYCLES+2, i.e. T+3 at the default setting.
- Throughput is one tile per SETTLE_CYCLES+2 cycles when no output stall occurs; `tile_ready` is combinational from state and `w_valid`.
- **Output stall.** While `out_valid=1 && out_ready=0`:
  - `out_data`, `out_count` and `out_last` are stable.
  - `tile_ready` is 0.
- **Output handshake.**
  - `out_valid` falls in the cycle after the handshake.
  - The earliest next tile accept is that same cycle.
- `math_w`/`math_i` are registered; `math_result` is sampled only in CAPTURE.

## Configuration
- `CONVO_CTRL_STATS_EN` defined adds two outputs:
  - `stat_tiles` (16 bits): increments on each tile handshake.
  - `stat_words` (16 bits): increments on each output handshake.
  - Both saturate at 0xFFFF and are cleared by `rst`.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- **Reset:** `rst` high 2 cycles -> `out_valid=0`, `tile_ready=0`, `math_sel=0`, `busy=0`, `math_w=0`; `tile_valid=1` with no `w_load` -> no accept.
- **Full word:** `w_load` 0x1FF, then tiles 0xFFFF, 0x0000, 0xFFFF, 0x0000 back-to-back, `out_ready=1` -> one word:
  - `out_data=0x0F0F`, `out_count=4`, `out_last=0`.
  - `out_valid` rises 3 cycles after the 4th accept.
- **Early flush:** `w_load` 0x1FF, tile 0xFFFF, then 0xFFFF with `tile_last=1` -> `out_data=0x00FF`, `out_count=2`, `out_last=1`.
- **Backpressure:** hold `out_ready=0` for 5 cycles while `out_valid=1` -> data, count and last stay stable and `tile_ready=0`; `out_ready=1` -> handshake, then `out_valid=0` next cycle.
- **Weight timing:**
  - Weight 0x1FF, tile 0xFFFF, assert `w_load` 0x000 during DRIVE -> nibble 0xF, weight still 0x1FF.
  - `w_load` 0x000 in IDLE concurrent with tile 0xFFFF -> nibble 0x0.
- **Reset mid-operation:** reset after 2 nibbles are packed, during DRIVE -> no word emitted, `busy=0`, `w_valid` cleared; with STATS_EN, `stat_tiles=0`.

Source files
------------

// File: rtl/convo_tile_sequencer.sv
// Sequencer for the XNOR/popcount conv unit: holds kernel weights, feeds
// tiles, captures 4-bit results and packs them into 16-bit output words.
//
// Parameters : SETTLE_CYCLES (1..15) cycles math_sel is held before capture,
//              PACK (1..4) result nibbles per output word
// Ports      : clk, rst (sync, active-high)
//              w_load, w_data[8:0]            kernel load (honoured in IDLE)
//              tile_valid/ready/data/last      input tile stream
//              math_w, math_i, math_sel        drive to math unit
//              math_result                     math unit output ([3:0] used)
//              out_valid/ready/data/count/last packed output stream
//              busy                            high outside IDLE
// Option     : CONVO_CTRL_STATS_EN adds stat_tiles / stat_words counters.
module convo_tile_sequencer #(
  parameter int SETTLE_CYCLES = 1,
  parameter int PACK          = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        w_load,
  input  logic [8:0]  w_data,
  input  logic        tile_valid,
  output logic        tile_ready,
  input  logic [15:0] tile_data,
  input  logic        tile_last,
  output logic [15:0] math_w,
  output logic [15:0] math_i,
  output logic        math_sel,
  input  logic [15:0] math_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [2:0]  out_count,
  output logic        out_last,
  output logic        busy
`ifdef CONVO_CTRL_STATS_EN
  ,
  output logic [15:0] stat_tiles,
  output logic [15:0] stat_words
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_CAPTURE,
    S_EMIT
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [2:0] PACK_N      = 3'(PACK);

  state_t      r_state;
  state_t      w_next;
  logic [8:0]  r_weight;
  logic        r_w_valid;
  logic [15:0] r_math_i;
  logic        r_last;
  logic [3:0]  r_cnt;
  logic [15:0] r_pack;
  logic [2:0]  r_idx;
  logic [2:0]  w_idx_inc;
  logic        w_tile_hs;
  logic        w_out_hs;
  logic        w_unused_hi;

  // Only the low nibble of the math unit result carries data.
  assign w_unused_hi = ^math_result[15:4];

  assign w_idx_inc = r_idx + 3'd1;
  assign w_tile_hs = (r_state == S_IDLE) && tile_valid && r_w_valid;
  assign w_out_hs  = (r_state == S_EMIT) && out_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    tile_ready = 1'b0;
    math_sel   = 1'b0;
    out_valid  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        tile_ready = r_w_valid;
        if (w_tile_hs) w_next = S_DRIVE;
      end
      S_DRIVE: begin
        math_sel = 1'b1;
        if (r_cnt == SETTLE_LAST) w_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        math_sel = 1'b1;
        if (w_idx_inc == PACK_N || r_last) w_next = S_EMIT;
        else                               w_next = S_IDLE;
      end
      S_EMIT: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_weight  <= '0;
      r_w_valid <= 1'b0;
      r_math_i  <= '0;
      r_last    <= 1'b0;
      r_cnt     <= '0;
      r_pack    <= '0;
      r_idx     <= '0;
    end else begin
      // A load in the same cycle as a tile accept takes effect before
      // DRIVE, so that tile is computed with the new kernel.
      if (r_state == S_IDLE && w_load) begin
        r_weight  <= w_data;
        r_w_valid <= 1'b1;
      end
      if (w_tile_hs) begin
        r_math_i <= tile_data;
        r_last   <= tile_last;
      end
      if (r_state == S_DRIVE) r_cnt <= r_cnt + 4'd1;
      else                    r_cnt <= '0;
      if (r_state == S_CAPTURE) begin
        r_pack[{r_idx[1:0], 2'b00} +: 4] <= math_result[3:0];
        r_idx <= w_idx_inc;
      end
      if (w_out_hs) begin
        r_pack <= '0;
        r_idx  <= '0;
        r_last <= 1'b0;
      end
    end
  end

  assign math_w    = {7'b0, r_weight};
  assign math_i    = r_math_i;
  assign out_data  = r_pack;
  assign out_count = r_idx;
  assign out_last  = r_last;
  assign busy      = (r_state != S_IDLE);

`ifdef CONVO_CTRL_STATS_EN
  logic [15:0] r_st_tiles;
  logic [15:0] r_st_words;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st_tiles <= '0;
      r_st_words <= '0;
    end else begin
      if (w_tile_hs && r_st_tiles != 16'hFFFF)
        r_st_tiles <= r_st_tiles + 16'd1;
      if (w_out_hs && r_st_words != 16'hFFFF)
        r_st_words <= r_st_words + 16'd1;
    end
  end

  assign stat_tiles = r_st_tiles;
  assign stat_words = r_st_words;
`endif

endmodule

// File: tb/tb_convo_tile_sequencer.sv
// Testbench for convo_tile_sequencer: behavioural math unit plus a
// scoreboard of expected packed words checked at each output handshake.
module tb_convo_tile_sequencer;
  localparam int S = 1;
  localparam int P = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        w_load = 1'b0;
  logic [8:0]  w_data = '0;
  logic        tile_valid = 1'b0;
  logic        tile_ready;
  logic [15:0] tile_data = '0;
  logic        tile_last = 1'b0;
  logic [15:0] math_w;
  logic [15:0] math_i;
  logic        math_sel;
  logic [15:0] math_result;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic [2:0]  out_count;
  logic        out_last;
  logic        busy;
`ifdef CONVO_CTRL_STATS_EN
  logic [15:0] stat_tiles;
  logic [15:0] stat_words;
`endif

  typedef struct packed {
    logic [15:0] d;
    logic [2:0]  n;
    logic        l;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_errors = 0;
  logic [8:0]  m_weight = '0;
  logic [15:0] m_pack = '0;
  int          m_idx = 0;

  always #5 clk = ~clk;

  convo_tile_sequencer #(.SETTLE_CYCLES(S), .PACK(P)) dut (
    .clk(clk), .rst(rst),
    .w_load(w_load), .w_data(w_data),
    .tile_valid(tile_valid), .tile_ready(tile_ready),
    .tile_data(tile_data), .tile_last(tile_last),
    .math_w(math_w), .math_i(math_i), .math_sel(math_sel),
    .math_result(math_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count),
    .out_last(out_last), .busy(busy)
`ifdef CONVO_CTRL_STATS_EN
    ,
    .stat_tiles(stat_tiles), .stat_words(stat_words)
`endif
  );

  // XNOR/popcount: each 3x3 window votes 1 when >=5 taps match.
  function automatic logic [3:0] conv(input logic [8:0] k,
                                      input logic [15:0] t);
    logic [3:0] r;
    int cnt;
    r = '0;
    for (int orw = 0; orw < 2; orw++)
      for (int oc = 0; oc < 2; oc++) begin
        cnt = 0;
        for (int kr = 0; kr < 3; kr++)
          for (int kc = 0; kc < 3; kc++)
            if (t[(orw+kr)*4 + oc + kc] == k[kr*3 + kc]) cnt++;
        r[orw*2 + oc] = (cnt >= 5);
      end
    return r;
  endfunction

  // Upper bits are junk so any use of them shows up in the data.
  assign math_result = {12'hA5C, conv(math_w[8:0], math_i)};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_word", {31'b0, out_valid}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("word_data", {16'b0, out_data}, {16'b0, e.d});
        chk("word_count", {29'b0, out_count}, {29'b0, e.n});
        chk("word_last", {31'b0, out_last}, {31'b0, e.l});
      end
    end
  end

  task automatic load_weight(input logic [8:0] d);
    w_load = 1'b1;
    w_data = d;
    @(posedge clk); #1;
    w_load = 1'b0;
    m_weight = d;
  endtask

  task automatic send_tile(input logic [15:0] d, input logic last,
                           input logic wl, input logic [8:0] wd);
    bit ok;
    exp_t e;
    tile_valid = 1'b1;
    tile_data  = d;
    tile_last  = last;
    w_load     = wl;
    w_data     = wd;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (tile_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    tile_valid = 1'b0;
    tile_last  = 1'b0;
    w_load     = 1'b0;
    if (!ok) begin
      chk("tile_accept_timeout", 32'd0, 32'd1);
    end else begin
      if (wl) m_weight = wd;
      m_pack[m_idx*4 +: 4] = conv(m_weight, d);
      m_idx++;
      if (m_idx == P || last) begin
        e.d = m_pack;
        e.n = 3'(m_idx);
        e.l = last;
        q.push_back(e);
        m_pack = '0;
        m_idx = 0;
      end
    end
  endtask

  task automatic wait_ov(input string tag);
    int i;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!out_valid && i < 30);
    chk(tag, {31'b0, out_valid}, 32'd1);
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (q.size() != 0 && i < 40) begin
      @(negedge clk);
      i++;
    end
    chk("drain", q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_tile_ready", {31'b0, tile_ready}, 32'd0);
    chk("rst_math_sel", {31'b0, math_sel}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_math_w", {16'b0, math_w}, 32'd0);
    rst = 1'b0;
    tile_valid = 1'b1;
    tile_data = 16'hFFFF;
    repeat (3) @(posedge clk);
    #1;
    chk("no_weight_ready", {31'b0, tile_ready}, 32'd0);
    chk("no_weight_busy", {31'b0, busy}, 32'd0);
    tile_valid = 1'b0;

    // Full word, back-to-back tiles.
    load_weight(9'h1FF);
    send_tile(16'hFFFF, 1'b0, 1'b0, 9'h0);
    send_tile(16'h0000, 1'b0, 1'b0, 9'h0);
    send_tile(16'hFFFF, 1'b0, 1'b0, 9'h0);
    send_tile(16'h0000, 1'b0, 1'b0, 9'h0);
    @(negedge clk);
    @(negedge clk);
    chk("ov_not_yet", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    chk("ov_rise_t3", {31'b0, out_valid}, 32'd1);
    chk("full_data", {16'b0, out_data}, 32'h0F0F);
    chk("full_count", {29'b0, out_count}, 32'd4);
    chk("full_last", {31'b0, out_last}, 32'd0);
    drain();

    // Early flush on tile_last.
    load_weight(9'h1FF);
    send_tile(16'hFFFF, 1'b0, 1'b0, 9'h0);
    send_tile(16'hFFFF, 1'b1, 1'b0, 9'h0);
    wait_ov("flush_ov");
    chk("flush_data", {16'b0, out_data}, 32'h00FF);
    chk("flush_count", {29'b0, out_count}, 32'd2);
    chk("flush_last", {31'b0, out_last}, 32'd1);
    drain();

    // Backpressure.
    out_ready = 1'b0;
    send_tile(16'h0000, 1'b0, 1'b0, 9'h0);
    send_tile(16'hFFFF, 1'b0, 1'b0, 9'h0);
    send_tile(16'h0F0F, 1'b0, 1'b0, 9'h0);
    send_tile(16'hF0F0, 1'b0, 1'b0, 9'h0);
    wait_ov("bp_ov");
    e = q[0];
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_data", {16'b0, out_data}, {16'b0, e.d});
      chk("bp_count", {29'b0, out_count}, {29'b0, e.n});
      chk("bp_last", {31'b0, out_last}, {31'b0, e.l});
      chk("bp_tile_ready", {31'b0, tile_ready}, 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_ov_fall", {31'b0, out_valid}, 32'd0);
    chk("bp_ready_after", {31'b0, tile_ready}, 32'd1);
    @(posedge clk); #1;
    chk("bp_queue_empty", q.size(), 32'd0);

    // w_load during DRIVE is ignored.
    send_tile(16'hFFFF, 1'b1, 1'b0, 9'h0);
    w_load = 1'b1;
    w_data = 9'h000;
    @(posedge clk); #1;
    w_load = 1'b0;
    chk("w_ignored", {16'b0, math_w}, 32'h01FF);
    wait_ov("wt_drive_ov");
    chk("wt_drive_nib", {16'b0, out_data}, 32'h000F);
    drain();

    // w_load concurrent with tile accept in IDLE.
    send_tile(16'hFFFF, 1'b1, 1'b1, 9'h000);
    wait_ov("wt_idle_ov");
    chk("wt_idle_nib", {16'b0, out_data}, 32'h0000);
    chk("wt_idle_math_w", {16'b0, math_w}, 32'h0000);
    drain();

    // Reset in DRIVE with two nibbles already packed.
    load_weight(9'h1FF);
    send_tile(16'hFFFF, 1'b0, 1'b0, 9'h0);
    send_tile(16'h0000, 1'b0, 1'b0, 9'h0);
    send_tile(16'hFFFF, 1'b0, 1'b0, 9'h0);
    chk("mid_in_drive", {31'b0, math_sel}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    m_pack = '0;
    m_idx = 0;
    m_weight = '0;
    chk("mid_busy", {31'b0, busy}, 32'd0);
    chk("mid_w_valid", {31'b0, tile_ready}, 32'd0);
    chk("mid_math_w", {16'b0, math_w}, 32'd0);
`ifdef CONVO_CTRL_STATS_EN
    chk("mid_stat_tiles", {16'b0, stat_tiles}, 32'd0);
`endif
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mid_no_word", {31'b0, out_valid}, 32'd0);
    end
    @(posedge clk); #1;
    load_weight(9'h1FF);
    send_tile(16'hFFFF, 1'b1, 1'b0, 9'h0);
    wait_ov("post_rst_ov");
    chk("post_rst_data", {16'b0, out_data}, 32'h000F);
    chk("post_rst_count", {29'b0, out_count}, 32'd1);
    drain();
`ifdef CONVO_CTRL_STATS_EN
    chk("stat_tiles", {16'b0, stat_tiles}, 32'd1);
    chk("stat_words", {16'b0, stat_words}, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
